// File: rtl/toggle_event_receiver.sv
// toggle_event_receiver
//   Receiving end of a toggle-signalled event line. Each level change of I
//   (after an optional retiming chain) becomes one event, queued in a
//   saturating pending counter and handed to the consumer over valid/ready.
//   Every consumed event flips O_ack back to the sender.
//
// Parameters
//   SYNC_STAGES  retiming flops on I (1..4)
//   CNT_WIDTH    pending counter width; max pending = 2^CNT_WIDTH-1
//
// Ports
//   CLK         clock, rising edge
//   RESETN      synchronous active-low reset
//   I           toggle event line
//   O_valid     at least one event pending (decoded from the counter)
//   O_ready     consumer accepts one event while O_valid=1
//   O_ack       acknowledge toggle, flips per consumed event
//   O_count     pending-event count
//   O_overflow  sticky, an event was dropped at saturation
//   CLR         clears O_overflow (a same-cycle drop wins)
module toggle_event_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 I,
  output logic                 O_valid,
  input  logic                 O_ready,
  output logic                 O_ack,
  output logic [CNT_WIDTH-1:0] O_count,
  output logic                 O_overflow,
  input  logic                 CLR
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   ev;
  logic                   take;

  assign ev      = sync_q[SYNC_STAGES-1] ^ prev_q;
  assign O_valid = |cnt_q;
  assign take    = O_valid & O_ready;
  assign O_count = cnt_q;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      cnt_q      <= '0;
      O_ack      <= 1'b0;
      O_overflow <= 1'b0;
    end else begin
      sync_q[0] <= I;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];

      // An arriving event and a consume in the same cycle cancel out.
      if (ev && !take && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_ONE;
      end else if (!ev && take) begin
        cnt_q <= cnt_q - CNT_ONE;
      end

      if (take) begin
        O_ack <= ~O_ack;
      end

      // A drop in the same cycle as CLR keeps the flag set.
      if (ev && !take && (cnt_q == CNT_MAX)) begin
        O_overflow <= 1'b1;
      end else if (CLR) begin
        O_overflow <= 1'b0;
      end
    end
  end

endmodule
